// File: rtl/cve2_obi_mem_responder.sv
// Word-array responder for the req/gnt/rvalid bus: byte-enabled writes, in-order fixed-latency responses.
// Optional macro CVE2_OBI_RANGE_ERR_EN: flag out-of-range addresses with err_o instead of wrapping.
module cve2_obi_mem_responder #(
  parameter int unsigned MemDepthWords  = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IdxW = $clog2(MemDepthWords);

  logic [31:0]            mem [MemDepthWords];
  logic [31:0]            offset;
  logic [IdxW-1:0]        idx;
  logic                   in_range;
  logic [31:0]            resp_rdata;
  logic                   resp_err;
  logic [ReadLatency-1:0] pipe_valid;
  logic [ReadLatency-1:0] pipe_err;
  logic [31:0]            pipe_rdata [ReadLatency];
  logic [2:0]             outstanding;

  assign offset = addr_i - BaseAddr;
  assign idx    = IdxW'(offset >> 2);

`ifdef CVE2_OBI_RANGE_ERR_EN
  // Addresses below BaseAddr wrap to large offsets and fall out of range as well.
  assign in_range = (offset >> (IdxW + 2)) == 32'd0;
  assign resp_err = ~in_range;
`else
  assign in_range = 1'b1;
  assign resp_err = 1'b0;
`endif

  // A retiring response only frees its slot from the next cycle on.
  assign gnt_o      = req_i & (outstanding < 3'(MaxOutstanding));
  assign resp_rdata = (we_i || !in_range) ? 32'd0 : mem[idx];

  // Array is intentionally not reset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < int'(ReadLatency); i++) pipe_rdata[i] <= 32'd0;
    end else begin
      pipe_valid[0] <= gnt_o;
      pipe_rdata[0] <= gnt_o ? resp_rdata : 32'd0;
      pipe_err[0]   <= gnt_o & resp_err;
      for (int i = 1; i < int'(ReadLatency); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid[ReadLatency-1];
  assign rdata_o  = pipe_rdata[ReadLatency-1];
  assign err_o    = pipe_err[ReadLatency-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= 3'd0;
    end else begin
      case ({gnt_o, rvalid_o})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Scoreboard bench for cve2_obi_mem_responder: instance a (latency 1) and instance b (latency 3, two outstanding).
// Expectations for the out-of-range case follow CVE2_OBI_RANGE_ERR_EN.
module tb_cve2_obi_mem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] gcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_gnt, a_we, a_rvalid, a_err;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_gnt, b_we, b_rvalid, b_err;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] cyc      = 32'd0;
  logic [31:0] m1 [1024];
  logic [31:0] m3 [1024];
  exp_t        q1 [$];
  exp_t        q3 [$];
  logic [31:0] b_gcyc [$];
  logic [31:0] b_rcyc [$];
  logic        b_rec = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  cve2_obi_mem_responder #(.MemDepthWords(1024), .BaseAddr(32'h0), .ReadLatency(1), .MaxOutstanding(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .gnt_o(a_gnt), .we_i(a_we), .be_i(a_be),
    .addr_i(a_addr), .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err));

  cve2_obi_mem_responder #(.MemDepthWords(1024), .BaseAddr(32'h0), .ReadLatency(3), .MaxOutstanding(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .gnt_o(b_gnt), .we_i(b_we), .be_i(b_be),
    .addr_i(b_addr), .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
`ifdef CVE2_OBI_RANGE_ERR_EN
    return a < 32'h1000;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // Scoreboards: pop on every response, push on every grant.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q1.delete();
    else begin
      if (a_rvalid) begin
        if (q1.size() == 0) chk("a_spurious_rvalid", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("a_rdata", a_rdata, e.rdata);
          chk("a_err", {31'd0, a_err}, {31'd0, e.err});
          chk("a_latency", cyc - e.gcyc, 32'd1);
        end
      end
      if (a_req && a_gnt) begin
        if (a_we) begin
          if (in_rng(a_addr)) m1[a_addr[11:2]] = merge(m1[a_addr[11:2]], a_wdata, a_be);
          q1.push_back('{32'd0, !in_rng(a_addr), cyc});
        end else
          q1.push_back('{in_rng(a_addr) ? m1[a_addr[11:2]] : 32'd0, !in_rng(a_addr), cyc});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q3.delete();
    else begin
      if (b_rvalid) begin
        if (b_rec) b_rcyc.push_back(cyc);
        if (q3.size() == 0) chk("b_spurious_rvalid", 32'd1, 32'd0);
        else begin
          e = q3.pop_front();
          chk("b_rdata", b_rdata, e.rdata);
          chk("b_err", {31'd0, b_err}, {31'd0, e.err});
          chk("b_latency", cyc - e.gcyc, 32'd3);
        end
      end
      if (b_req && b_gnt) begin
        if (b_rec) b_gcyc.push_back(cyc);
        if (b_we) begin
          m3[b_addr[11:2]] = merge(m3[b_addr[11:2]], b_wdata, b_be);
          q3.push_back('{32'd0, 1'b0, cyc});
        end else
          q3.push_back('{m3[b_addr[11:2]], 1'b0, cyc});
      end
    end
  end

  // Drives one request starting next cycle; the grant must come in the same cycle.
  task automatic a_issue(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
    @(negedge clk);
    chk("a_gnt", {31'd0, a_gnt}, 32'd1);
  endtask

  task automatic a_idle();
    @(posedge clk); #1;
    a_req = 1'b0; a_we = 1'b0; a_be = 4'h0;
  endtask

  task automatic b_issue(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd,
                         output int waited);
    int k;
    @(posedge clk); #1;
    b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
    @(negedge clk);
    k = 0;
    while (!b_gnt && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b_gnt_wait", {31'd0, b_gnt}, 32'd1);
    waited = k;
  endtask

  task automatic b_idle();
    @(posedge clk); #1;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w;
    logic [31:0] rd;
    logic [31:0] exp_g [4];
    logic [31:0] exp_r [4];
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 4; exp_g[3] = 5;
    exp_r[0] = 3; exp_r[1] = 4; exp_r[2] = 7; exp_r[3] = 8;
    for (int i = 0; i < 1024; i++) begin m1[i] = 32'd0; m3[i] = 32'd0; end
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 32'd0; a_wdata = 32'd0;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 32'd0; b_wdata = 32'd0;
    wait_cycles(3);
    chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_a_err", {31'd0, a_err}, 32'd0);
    chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_b_err", {31'd0, b_err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // T1 and T2: full write then read, partial byte-enable merge read right after the write.
    a_issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    a_issue(1'b0, 4'h0, 32'h10, 32'h0);
    a_issue(1'b1, 4'hF, 32'h20, 32'h11223344);
    a_issue(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    a_issue(1'b0, 4'h0, 32'h20, 32'h0);
    a_idle();
    wait_cycles(2);
    chk("t2_model_word", m1[8], 32'h11BB33DD);

    // be=0 write, single high byte, last word of the array.
    a_issue(1'b1, 4'h0, 32'h10, 32'h12345678);
    a_issue(1'b0, 4'h0, 32'h10, 32'h0);
    a_issue(1'b1, 4'b1000, 32'h20, 32'hEE000000);
    a_issue(1'b0, 4'h0, 32'h20, 32'h0);
    a_issue(1'b1, 4'hF, 32'hFFC, 32'hA5A5_5A5A);
    a_issue(1'b0, 4'h0, 32'hFFC, 32'h0);
    for (int i = 0; i < 4; i++) a_issue(1'b1, 4'hF >> i, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 4; i++) a_issue(1'b0, 4'h0, 32'h100 + 32'(4 * i), 32'h0);

    // T4: word 0 known, then write just past the array and read word 0.
    a_issue(1'b1, 4'hF, 32'h0, 32'h01020304);
    a_issue(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
    a_issue(1'b0, 4'h0, 32'h0, 32'h0);
    a_issue(1'b0, 4'h0, 32'h1004, 32'h0);
    a_idle();
    wait_cycles(3);
    chk("a_drain", 32'(q1.size()), 32'd0);

    // T3: latency 3 with two slots, four reads held back-to-back.
    for (int i = 0; i < 4; i++) b_issue(1'b1, 4'hF, 32'(4 * i), 32'h100 + 32'(i), w);
    b_idle();
    wait_cycles(6);
    b_rec = 1'b1;
    for (int i = 0; i < 4; i++) b_issue(1'b0, 4'h0, 32'(4 * i), 32'h0, w);
    b_idle();
    wait_cycles(6);
    b_rec = 1'b0;
    chk("t3_grants", 32'(b_gcyc.size()), 32'd4);
    chk("t3_rvalids", 32'(b_rcyc.size()), 32'd4);
    if (b_gcyc.size() == 4 && b_rcyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3_gnt_cycle", b_gcyc[i] - b_gcyc[0], exp_g[i]);
        chk("t3_rvalid_cycle", b_rcyc[i] - b_gcyc[0], exp_r[i]);
      end
    end

    // T5: reset with two reads in flight.
    b_issue(1'b0, 4'h0, 32'h0, 32'h0, w);
    b_issue(1'b0, 4'h0, 32'h4, 32'h0, w);
    @(posedge clk); #1;
    b_req = 1'b0; rst_n = 1'b0;
    wait_cycles(2);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_rvalid_quiet", {31'd0, b_rvalid}, 32'd0);
    end
    b_issue(1'b0, 4'h0, 32'h0, 32'h0, w);
    chk("t5_gnt_immediate0", 32'(w), 32'd0);
    b_issue(1'b0, 4'h0, 32'h4, 32'h0, w);
    chk("t5_gnt_immediate1", 32'(w), 32'd0);
    b_idle();
    rd = m3[1];
    chk("t5_model_word1", rd, 32'h101);
    wait_cycles(6);
    chk("b_drain", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
